// File: rtl/mul_pkg.sv
// Shared types and constants for the 16x16 shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mul16_if.sv
// Operand/product handshake bundle for shift_add_mul16.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the product side.
interface shift_add_mul16_if;
  import mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] P;
  logic              busy;

  // Producer/consumer side of the multiplier.
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P, busy
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P, busy
  );
endinterface

// File: rtl/adder32.sv
// Plain 32-bit adder; carry-out is not produced.
// Latency: combinational.
// Backpressure: none.
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] S
);

  // Single shared add; wrap-around is the intended behaviour.
  always_comb begin
    S = a_i + b_i;
  end

endmodule

// File: rtl/shift_add_mul16.sv
// 16x16->32 sequential shift-add multiplier; SIGNED_MUL_EN selects two's-complement operands.
// Latency: out_valid 16 cycles after accept (17 with SIGNED_MUL_EN, extra FIX negate cycle).
// Backpressure: one operation in flight; in_ready only in IDLE, product held in DONE until out_ready.
module shift_add_mul16
  import mul_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  shift_add_mul16_if.slave    bus
);

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   add_a, add_b, add_s;
  logic [OP_W-1:0]     a_mag, b_mag;
  logic                accept;
  logic                last_iter;
`ifdef SIGNED_MUL_EN
  logic                neg_q, neg_d;
`endif

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_iter = (cnt_q == CNT_W'(MUL_ITER - 1));

  adder32 u_add (
    .a_i (add_a),
    .b_i (add_b),
    .S   (add_s)
  );

`ifdef SIGNED_MUL_EN
  // Adder input mux: RUN accumulates, FIX negates acc, and IDLE reuses the
  // idle adder to form |A| in the low half and |B| in the high half at once.
  // A negative 16-bit value never produces a carry out of ~x+1, so the halves
  // cannot disturb each other.
  always_comb begin
    add_a = acc_q;
    add_b = mcand_q;
    if (state_q == IDLE) begin
      add_a = {(bus.B[OP_W-1] ? ~bus.B : bus.B), (bus.A[OP_W-1] ? ~bus.A : bus.A)};
      add_b = {{(OP_W-1){1'b0}}, bus.B[OP_W-1], {(OP_W-1){1'b0}}, bus.A[OP_W-1]};
    end else if (state_q == FIX) begin
      add_a = ~acc_q;
      add_b = {{(PROD_W-1){1'b0}}, 1'b1};
    end
  end

  assign a_mag = add_s[OP_W-1:0];
  assign b_mag = add_s[PROD_W-1:OP_W];
`else
  // Adder inputs: only the RUN accumulate uses the adder in the unsigned build.
  always_comb begin
    add_a = acc_q;
    add_b = mcand_q;
  end

  assign a_mag = bus.A;
  assign b_mag = bus.B;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: fixed 16 RUN cycles, optional FIX, hold DONE until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = RUN;
`ifdef SIGNED_MUL_EN
      RUN:  if (last_iter) state_d = FIX;
      FIX:  state_d = DONE;
`else
      RUN:  if (last_iter) state_d = DONE;
`endif
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: product is forced to zero unless it is being presented.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
    bus.P         = (state_q == DONE) ? acc_q : '0;
  end

  // Datapath next-state: load on accept, one shift-add step per RUN cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef SIGNED_MUL_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d    = '0;
          mcand_d  = {{(PROD_W-OP_W){1'b0}}, a_mag};
          mplier_d = b_mag;
          cnt_d    = '0;
`ifdef SIGNED_MUL_EN
          neg_d    = bus.A[OP_W-1] ^ bus.B[OP_W-1];
`endif
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = add_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
`ifdef SIGNED_MUL_EN
      FIX: begin
        if (neg_q) acc_d = add_s;
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef SIGNED_MUL_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef SIGNED_MUL_EN
      neg_q    <= neg_d;
`endif
    end
  end

endmodule

// File: doc/shift_add_mul16.md
SHIFT_ADD_MUL16 -- requirements
Module: shift_add_mul16

Interface
REQ-001 SHALL have no parameters; widths fixed at 16x16 -> 32.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  operand pair valid.
REQ-005 in_ready  out  1  block can accept an operand pair.
REQ-006 A  in  16  multiplicand.
REQ-007 B  in  16  multiplier.
REQ-008 out_valid  out  1  product P valid.
REQ-009 out_ready  in  1  consumer accepts P.
REQ-010 P  out  32  product.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX, DONE.
REQ-013 in_ready SHALL equal (state==IDLE); in_valid in any other state is ignored.
REQ-014 Accept = in_valid & in_ready at a rising edge; A and B SHALL be captured then, IDLE->RUN; later changes on A/B have no effect.
REQ-015 At accept: acc=0, mcand=zero-extended 32-bit operand A, mplier=operand B, cnt=0.
REQ-016 Each RUN cycle: if mplier[0], acc <= acc + mcand via the 32-bit adder; mcand <<= 1; mplier >>= 1; cnt++.
REQ-017 RUN SHALL last exactly 16 cycles regardless of operand values (zero operands included); the adder carry-out is discarded.
REQ-018 After the 16th RUN cycle: FIX if SIGNED_MUL_EN is defined, otherwise DONE.
REQ-019 Latency: out_valid SHALL rise 16 cycles after the accept edge (17 with SIGNED_MUL_EN).
REQ-020 In DONE, out_valid=1 and P=acc, held stable until out_valid & out_ready.
REQ-021 On an out_valid & out_ready edge: DONE->IDLE; in_ready is high the next cycle; no same-cycle accept of a new pair.
REQ-022 out_ready while out_valid=0 SHALL be ignored.
REQ-023 P SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, acc/mcand/mplier/cnt=0, out_valid=0, busy=0, P=0, and in_ready=1 at any point, including mid-RUN; the in-flight operation is discarded.
REQ-025 The first accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-026 Macro SIGNED_MUL_EN: when defined, A and B are two's complement.
- At accept, magnitudes |A| and |B| are loaded; -32768 maps to 0x8000.
- neg = A[15]^B[15] is stored.
- FIX (1 cycle): acc <= ~acc + 1 if neg, then DONE.
- P is the 32-bit two's-complement product.
REQ-027 Without SIGNED_MUL_EN, operands are unsigned, the FIX state and neg register are absent, and RUN goes straight to DONE.

Structure
REQ-028 A shared package mul_pkg SHALL hold the state encoding typedef, MUL_ITER=16, and the operand and product width constants.
REQ-029 A single sub-module instance of the existing adder32 block SHALL perform the RUN accumulate (inputs acc and mcand; output S to acc).
- The FIX-state negate SHALL also use this instance (operands ~acc and 1), with a mux on the adder inputs.
- No other adder is permitted.

Verification
REQ-030 A=3, B=5 accepted -> out_valid 16 cycles later, P=0x0000000F; in_ready is 0 for the whole operation.
REQ-031 Unsigned A=0xFFFF, B=0xFFFF -> P=0xFFFE0001; A=0, B=0x1234 -> P=0 with the same 16-cycle latency.
REQ-032 SIGNED_MUL_EN: A=0xFFFE (-2), B=3 -> P=0xFFFFFFFA after 17 cycles; A=0x8000, B=0x8000 -> P=0x40000000.
REQ-033 Backpressure: out_ready held low for 5 cycles after out_valid -> P and out_valid stable; in_valid pulses in this window are ignored; raising out_ready -> IDLE next cycle.
REQ-034 rst_n pulsed low at RUN cycle 8 of A=7, B=9 -> out_valid=0, P=0, in_ready=1 at once; the next accept of 2x2 gives P=4 with normal latency.
